// File: rtl/mem_map_pkg.sv
// Address map, STATUS layout and TX FIFO sizing shared by the memory/IO bridge
// and its TX FIFO.
package mem_map_pkg;
  localparam logic [31:0] MMIO_LED_ADDR    = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_TXDATA_ADDR = 32'hFFFF_0004;
  localparam logic [31:0] MMIO_STATUS_ADDR = 32'hFFFF_0008;
  localparam logic [31:0] MMIO_CYCLES_ADDR = 32'hFFFF_000C;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_COUNT_W   = 3;
  localparam int STATUS_OVF_BIT   = 5;

  localparam int TX_FIFO_DEPTH = 4;
  localparam int TX_PTR_W      = 2;
  localparam int TX_CNT_W      = 3;

  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;
endpackage

// File: rtl/tx_fifo.sv
// Four-entry byte FIFO feeding the TX consumer. Handshake: a byte transfers on
// a rising edge where valid (!empty_o) and ready (pop_i) are both high.
module tx_fifo
  import mem_map_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                push_i,
  input  logic [7:0]          push_data_i,
  input  logic                pop_i,
  output logic [7:0]          data_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [TX_CNT_W-1:0] count_o
);
  logic [7:0]          mem_q [TX_FIFO_DEPTH];
  logic [7:0]          mem_d [TX_FIFO_DEPTH];
  logic [TX_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TX_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TX_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == TX_CNT_W'(TX_FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Fullness is judged on the start-of-cycle count, so a pop never makes room
  // for a push on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + TX_CNT_W'(do_push) - TX_CNT_W'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + TX_PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + TX_PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/mem_io_bridge.sv
// Single-cycle data-memory port for a small core: word RAM at address 0 plus
// LED, TX FIFO, STATUS and free-running cycle counter registers at 0xFFFF_0000.
module mem_io_bridge
  import mem_map_pkg::*;
#(
  parameter int RAM_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_wmem_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  output logic [31:0] read_data_o32,
  output logic [7:0]  led_o8,
  output logic [7:0]  tx_data_o8,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);
  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [31:0]         ram_q [RAM_WORDS];
  logic [RAM_AW-1:0]   ram_idx;
  logic                sel_ram, sel_led, sel_txdata, sel_status, sel_cycles;
  logic [7:0]          led_q, led_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         cycles_q, cycles_d;
  logic [31:0]         status_word;
  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [TX_CNT_W-1:0] fifo_count;
  logic                unused_addr_bits;

  // Byte lanes are not decoded: every access is a full word.
  assign unused_addr_bits = ^addr_i32[1:0];
  assign ram_idx    = addr_i32[RAM_AW+1:2];
  assign sel_ram    = (addr_i32[31:RAM_AW+2] == '0);
  assign sel_led    = (addr_i32[31:2] == MMIO_LED_ADDR[31:2]);
  assign sel_txdata = (addr_i32[31:2] == MMIO_TXDATA_ADDR[31:2]);
  assign sel_status = (addr_i32[31:2] == MMIO_STATUS_ADDR[31:2]);
  assign sel_cycles = (addr_i32[31:2] == MMIO_CYCLES_ADDR[31:2]);

  assign fifo_push  = enable_wmem_i && sel_txdata && !fifo_full;
  assign fifo_pop   = tx_valid_o && tx_ready_i;
  assign tx_valid_o = !fifo_empty;
  assign led_o8     = led_q;

  tx_fifo u_tx_fifo (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (fifo_push),
    .push_data_i (write_data_i32[7:0]),
    .pop_i       (fifo_pop),
    .data_o      (tx_data_o8),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    status_word                                     = '0;
    status_word[STATUS_FULL_BIT]                    = fifo_full;
    status_word[STATUS_EMPTY_BIT]                   = fifo_empty;
    status_word[STATUS_COUNT_LSB +: STATUS_COUNT_W] = fifo_count;
    status_word[STATUS_OVF_BIT]                     = ovf_q;
  end

  always_comb begin
    read_data_o32 = UNMAPPED_RDATA;
    if (sel_ram)         read_data_o32 = ram_q[ram_idx];
    else if (sel_led)    read_data_o32 = {24'h0, led_q};
    else if (sel_txdata) read_data_o32 = 32'h0;
    else if (sel_status) read_data_o32 = status_word;
    else if (sel_cycles) read_data_o32 = cycles_q;
  end

  // A dropped TXDATA write is applied after the STATUS clear so it wins.
  always_comb begin
    led_d    = led_q;
    ovf_d    = ovf_q;
    cycles_d = cycles_q + 32'd1;
    if (enable_wmem_i) begin
      if (sel_led)                 led_d    = write_data_i32[7:0];
      if (sel_status)              ovf_d    = 1'b0;
      if (sel_txdata && fifo_full) ovf_d    = 1'b1;
      if (sel_cycles)              cycles_d = 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      led_q    <= '0;
      ovf_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      led_q    <= led_d;
      ovf_q    <= ovf_d;
      cycles_q <= cycles_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && enable_wmem_i && sel_ram) begin
      ram_q[ram_idx] <= write_data_i32;
    end
  end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed scenarios then random traffic, all checked
// against an abstract model of the memory map kept here.
module tb_mem_io_bridge;
  localparam int RAM_WORDS = 64;
  localparam logic [31:0] A_LED    = 32'hFFFF_0000;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_CYCLES = 32'hFFFF_000C;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_wmem_i = 1'b0;
  logic [31:0] addr_i32 = '0;
  logic [31:0] write_data_i32 = '0;
  logic [31:0] read_data_o32;
  logic [7:0]  led_o8;
  logic [7:0]  tx_data_o8;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] ref_ram [RAM_WORDS];
  bit          ref_ram_vld [RAM_WORDS];
  logic [7:0]  ref_led;
  bit          ref_ovf;
  logic [31:0] ref_cycles;
  logic [7:0]  exp_q[$];
  bit          model_valid = 1'b0;

  logic [31:0] obs_rd;
  logic [7:0]  obs_tx_data;
  logic        obs_tx_valid;

  mem_io_bridge #(.RAM_WORDS(RAM_WORDS)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .enable_wmem_i  (enable_wmem_i),
    .addr_i32       (addr_i32),
    .write_data_i32 (write_data_i32),
    .read_data_o32  (read_data_o32),
    .led_o8         (led_o8),
    .tx_data_o8     (tx_data_o8),
    .tx_valid_o     (tx_valid_o),
    .tx_ready_i     (tx_ready_i)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Returns 0 when the expected value is unknown (RAM word never written).
  function automatic bit ref_read(input logic [31:0] a, output logic [31:0] v);
    logic [31:0] w;
    int n;
    w = {a[31:2], 2'b00};
    n = exp_q.size();
    v = 32'h0;
    if (w < 32'(RAM_WORDS * 4)) begin
      if (!ref_ram_vld[int'(w >> 2)]) return 1'b0;
      v = ref_ram[int'(w >> 2)];
    end else if (w == A_LED) begin
      v = {24'h0, ref_led};
    end else if (w == A_STATUS) begin
      v = 32'((n == 4 ? 1 : 0) + (n == 0 ? 2 : 0) + 4 * n + (ref_ovf ? 32 : 0));
    end else if (w == A_CYCLES) begin
      v = ref_cycles;
    end
    return 1'b1;
  endfunction

  // driver: one bus cycle, outputs checked before the edge, model advanced after
  task automatic step(input bit rst, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input bit rdy);
    logic [31:0] ev;
    logic [31:0] w;
    bit known;
    int n;
    @(negedge clk_i);
    reset_i = rst;
    enable_wmem_i = we;
    addr_i32 = a;
    write_data_i32 = wd;
    tx_ready_i = rdy;
    #1;
    obs_rd = read_data_o32;
    obs_tx_data = tx_data_o8;
    obs_tx_valid = tx_valid_o;
    if (model_valid) begin
      known = ref_read(a, ev);
      if (known) check_eq("read_data", obs_rd, ev);
      check_eq("led", 32'(led_o8), 32'(ref_led));
      check_eq("tx_valid", 32'(obs_tx_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) check_eq("tx_data", 32'(obs_tx_data), 32'(exp_q[0]));
    end
    @(posedge clk_i);
    if (rst) begin
      ref_led = 8'h0;
      ref_ovf = 1'b0;
      ref_cycles = 32'h0;
      exp_q.delete();
      model_valid = 1'b1;
    end else begin
      w = {a[31:2], 2'b00};
      n = exp_q.size();
      if (n > 0 && rdy) void'(exp_q.pop_front());
      if (we) begin
        if (w < 32'(RAM_WORDS * 4)) begin
          ref_ram[int'(w >> 2)] = wd;
          ref_ram_vld[int'(w >> 2)] = 1'b1;
        end else if (w == A_LED) begin
          ref_led = wd[7:0];
        end else if (w == A_TXDATA) begin
          if (n == 4) ref_ovf = 1'b1;
          else exp_q.push_back(wd[7:0]);
        end else if (w == A_STATUS) begin
          ref_ovf = 1'b0;
        end
      end
      ref_cycles = (we && w == A_CYCLES) ? 32'h0 : ref_cycles + 32'd1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] lo;
    lo = 32'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0, 1, 2, 3: rand_addr = 32'($urandom_range(0, RAM_WORDS * 4 - 1));
      4:          rand_addr = A_LED | lo;
      5, 6:       rand_addr = A_TXDATA | lo;
      7:          rand_addr = A_STATUS | lo;
      8:          rand_addr = A_CYCLES | lo;
      default:    rand_addr = $urandom_range(0, 1) ? (32'hFFFF_0010 | lo)
                                                   : (32'h0000_0100 + 32'($urandom_range(0, 4095)));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) ref_ram_vld[i] = 1'b0;

    // reset state and CYCLES counting
    step(1, 0, 32'h0, 32'h0, 0);
    step(0, 0, A_CYCLES, 32'h0, 0);
    check_eq("cycles_after_reset", obs_rd, 32'h0);
    step(0, 0, A_CYCLES, 32'h0, 0);
    check_eq("cycles_plus_one", obs_rd, 32'h1);
    step(0, 0, A_STATUS, 32'h0, 0);
    check_eq("status_after_reset", obs_rd, 32'h0000_0002);

    // RAM
    step(0, 1, 32'h0000_0010, 32'h1234_5678, 0);
    step(0, 0, 32'h0000_0010, 32'h0, 0);
    check_eq("ram_load_aligned", obs_rd, 32'h1234_5678);
    step(0, 0, 32'h0000_0013, 32'h0, 0);
    check_eq("ram_load_unaligned", obs_rd, 32'h1234_5678);
    step(0, 0, 32'h0000_0100, 32'h0, 0);
    check_eq("ram_out_of_range", obs_rd, 32'h0);

    // LED
    step(0, 1, A_LED, 32'hABCD_00A5, 0);
    step(0, 0, A_LED, 32'h0, 0);
    check_eq("led_port", 32'(led_o8), 32'h0000_00A5);
    check_eq("led_read", obs_rd, 32'h0000_00A5);

    // FIFO fill with overflow, then drain
    for (int i = 1; i <= 5; i++) step(0, 1, A_TXDATA, 32'(8'h11 * i), 0);
    step(0, 0, A_STATUS, 32'h0, 0);
    check_eq("status_full_ovf", obs_rd, 32'h0000_0031);
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, A_STATUS, 32'h0, 1);
      check_eq("drain_byte", 32'(obs_tx_data), 32'(8'h11 * i));
    end
    step(0, 0, A_STATUS, 32'h0, 1);
    check_eq("status_drained", obs_rd, 32'h0000_0022);

    // full FIFO: TXDATA write and pop on the same edge
    step(0, 1, A_STATUS, 32'h0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, A_TXDATA, 32'(8'hA0 + i), 0);
    step(0, 1, A_TXDATA, 32'h99, 1);
    step(0, 0, A_STATUS, 32'h0, 0);
    check_eq("status_pop_and_drop", obs_rd, 32'h0000_002C);
    step(0, 1, A_STATUS, 32'hDEAD_BEEF, 0);
    step(0, 0, A_STATUS, 32'h0, 0);
    check_eq("status_ovf_cleared", obs_rd, 32'h0000_000C);
    for (int i = 0; i < 3; i++) step(0, 0, A_TXDATA, 32'h0, 1);

    // CYCLES clear and wrap
    step(0, 1, A_CYCLES, 32'h5555_5555, 0);
    step(0, 0, A_CYCLES, 32'h0, 0);
    check_eq("cycles_cleared", obs_rd, 32'h0);
    step(0, 0, A_CYCLES, 32'h0, 0);
    check_eq("cycles_after_clear", obs_rd, 32'h1);
    #2;
    force dut.cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycles_q;
    ref_cycles = 32'hFFFF_FFFF;
    step(0, 0, A_CYCLES, 32'h0, 0);
    check_eq("cycles_max", obs_rd, 32'hFFFF_FFFF);
    step(0, 0, A_CYCLES, 32'h0, 0);
    check_eq("cycles_wrap", obs_rd, 32'h0);

    // reset mid-transfer overrides a write and a pending pop
    step(0, 1, A_LED, 32'h0000_003C, 0);
    for (int i = 0; i < 3; i++) step(0, 1, A_TXDATA, 32'(8'h61 + i), 0);
    step(1, 1, A_LED, 32'h0000_00FF, 1);
    step(0, 0, A_STATUS, 32'h0, 1);
    check_eq("rst_tx_valid", 32'(obs_tx_valid), 32'h0);
    check_eq("rst_status", obs_rd, 32'h0000_0002);
    check_eq("rst_led", 32'(led_o8), 32'h0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 4, rand_addr(),
           $urandom(), $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
